// File: rtl/count_sequence_checker.sv
// ============================================================================
// count_sequence_checker: monitors a free-running counter for +1 mod 2^WIDTH
// progression (or return to 0 after its clear) and reports errors and wraps.
// Revision: 1.0
// ============================================================================
`default_nettype none

module count_sequence_checker #(
  parameter int WIDTH     = 4,
  parameter int ERR_LIMIT = 3,
  parameter int WRAP_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  cnt_in,
  input  logic              cnt_clr,
  input  logic              clear_fault,
  output logic              locked,
  output logic              fault,
  output logic [1:0]        state,
  output logic              err_pulse,
  output logic [7:0]        err_count,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SYNC  = 2'b01,
    TRACK = 2'b10,
    FAULT = 2'b11
  } state_t;

  localparam logic [WIDTH-1:0]  c_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]  c_MAX      = {WIDTH{1'b1}};
  localparam logic [WRAP_W-1:0] c_WRAP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]        c_LIMIT    = 4'(ERR_LIMIT);

  state_t            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_prev;
  logic              r_clr_q;
  logic [3:0]        r_consec, w_consec_nxt, w_consec_inc;
  logic [7:0]        r_err_count, w_err_count_nxt, w_err_sat_inc;
  logic [WRAP_W-1:0] r_wrap_count, w_wrap_count_nxt;
  logic              r_err_pulse, w_err_pulse_nxt;
  logic              r_wrap_pulse, w_wrap_pulse_nxt;
  logic [WIDTH-1:0]  w_exp;
  logic              w_match, w_wrap_evt;

  // A pending clear makes the next sample expect 0; otherwise expect prev+1.
  assign w_exp         = r_clr_q ? '0 : (r_prev + c_ONE);
  assign w_match       = (cnt_in == w_exp);
  assign w_wrap_evt    = (r_prev == c_MAX) && (cnt_in == '0) && !r_clr_q;
  assign w_consec_inc  = r_consec + 4'd1;
  assign w_err_sat_inc = (r_err_count == 8'hFF) ? 8'hFF : (r_err_count + 8'd1);

  always_comb begin
    w_state_nxt      = r_state;
    w_consec_nxt     = r_consec;
    w_err_count_nxt  = r_err_count;
    w_wrap_count_nxt = r_wrap_count;
    w_err_pulse_nxt  = 1'b0;
    w_wrap_pulse_nxt = 1'b0;

    case (r_state)
      IDLE: begin
        w_state_nxt = SYNC;
        if (clear_fault) w_err_count_nxt = '0;
      end
      SYNC: begin
        if (clear_fault) w_err_count_nxt = '0;
        if (w_match) w_state_nxt = TRACK;
      end
      TRACK: begin
        if (w_match) begin
          w_consec_nxt = '0;
          if (clear_fault) w_err_count_nxt = '0;
          if (w_wrap_evt) begin
            w_wrap_pulse_nxt = 1'b1;
            w_wrap_count_nxt = r_wrap_count + c_WRAP_ONE;
          end
        end else begin
          // A mismatch outranks a simultaneous clear_fault: count restarts at 1.
          w_err_pulse_nxt = 1'b1;
          w_err_count_nxt = clear_fault ? 8'd1 : w_err_sat_inc;
          w_consec_nxt    = w_consec_inc;
          if (w_consec_inc == c_LIMIT) w_state_nxt = FAULT;
        end
      end
      FAULT: begin
        if (clear_fault) begin
          w_state_nxt     = SYNC;
          w_err_count_nxt = '0;
          w_consec_nxt    = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_prev       <= '0;
      r_clr_q      <= 1'b0;
      r_consec     <= '0;
      r_err_count  <= '0;
      r_wrap_count <= '0;
      r_err_pulse  <= 1'b0;
      r_wrap_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_prev       <= cnt_in;
      r_clr_q      <= cnt_clr;
      r_consec     <= w_consec_nxt;
      r_err_count  <= w_err_count_nxt;
      r_wrap_count <= w_wrap_count_nxt;
      r_err_pulse  <= w_err_pulse_nxt;
      r_wrap_pulse <= w_wrap_pulse_nxt;
    end
  end

  assign state      = r_state;
  assign locked     = (r_state == TRACK);
  assign fault      = (r_state == FAULT);
  assign err_pulse  = r_err_pulse;
  assign err_count  = r_err_count;
  assign wrap_pulse = r_wrap_pulse;
  assign wrap_count = r_wrap_count;

endmodule

`default_nettype wire

// File: tb/tb_count_sequence_checker.sv
// ============================================================================
// tb_count_sequence_checker: directed self-checking bench for the checker.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_count_sequence_checker;

  logic       clk;
  logic       reset;
  logic [3:0] cnt_in;
  logic       cnt_clr;
  logic       clear_fault;
  logic       locked;
  logic       fault;
  logic [1:0] state;
  logic       err_pulse;
  logic [7:0] err_count;
  logic       wrap_pulse;
  logic [7:0] wrap_count;

  int n_cmp;
  int n_fail;

  count_sequence_checker #(
    .WIDTH(4), .ERR_LIMIT(3), .WRAP_W(8)
  ) dut (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .cnt_clr(cnt_clr),
    .clear_fault(clear_fault), .locked(locked), .fault(fault), .state(state),
    .err_pulse(err_pulse), .err_count(err_count),
    .wrap_pulse(wrap_pulse), .wrap_count(wrap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Present one counter sample, then look at the outputs 1 ns after the edge.
  task automatic step(input logic [3:0] v, input logic c, input logic cf);
    cnt_in = v; cnt_clr = c; clear_fault = cf;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #7;
    n_cmp++; if (state !== 2'b00)    begin n_fail++; $display("FAIL rst_state: got %0d expected 0", state); end
    n_cmp++; if (locked !== 1'b0)    begin n_fail++; $display("FAIL rst_locked: got %0b expected 0", locked); end
    n_cmp++; if (fault !== 1'b0)     begin n_fail++; $display("FAIL rst_fault: got %0b expected 0", fault); end
    n_cmp++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_err_pulse: got %0b expected 0", err_pulse); end
    n_cmp++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL rst_err_count: got %0d expected 0", err_count); end
    n_cmp++; if (wrap_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_wrap_pulse: got %0b expected 0", wrap_pulse); end
    n_cmp++; if (wrap_count !== 8'd0) begin n_fail++; $display("FAIL rst_wrap_count: got %0d expected 0", wrap_count); end
    #3;
    reset = 1'b1;
  endtask

  task automatic test_lock;
    step(4'd0, 1'b1, 1'b0);
    n_cmp++; if (state !== 2'b01) begin n_fail++; $display("FAIL lock_sync: got %0d expected 1", state); end
    step(4'd0, 1'b1, 1'b0);
    n_cmp++; if (state !== 2'b10) begin n_fail++; $display("FAIL lock_track: got %0d expected 2", state); end
    step(4'd0, 1'b0, 1'b0);
    step(4'd1, 1'b0, 1'b0);
    n_cmp++; if (locked !== 1'b1)    begin n_fail++; $display("FAIL lock_locked: got %0b expected 1", locked); end
    n_cmp++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL lock_err_count: got %0d expected 0", err_count); end
  endtask

  task automatic test_wrap;
    logic [3:0] v;
    logic       exp_w;
    for (int k = 0; k < 31; k++) begin
      v = 4'((2 + k) % 16);
      exp_w = (v == 4'd0);
      step(v, 1'b0, 1'b0);
      n_cmp++; if (wrap_pulse !== exp_w) begin n_fail++; $display("FAIL wrap_pulse v=%0d: got %0b expected %0b", v, wrap_pulse, exp_w); end
      n_cmp++; if (err_pulse !== 1'b0)   begin n_fail++; $display("FAIL wrap_err_pulse v=%0d: got %0b expected 0", v, err_pulse); end
    end
    n_cmp++; if (wrap_count !== 8'd2) begin n_fail++; $display("FAIL wrap_count: got %0d expected 2", wrap_count); end
    n_cmp++; if (err_count !== 8'd0)  begin n_fail++; $display("FAIL wrap_err_count: got %0d expected 0", err_count); end
  endtask

  task automatic test_skip;
    for (int v = 1; v <= 5; v++) step(4'(v), 1'b0, 1'b0);
    step(4'd7, 1'b0, 1'b0);
    n_cmp++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL skip_err_pulse: got %0b expected 1", err_pulse); end
    n_cmp++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL skip_err_count: got %0d expected 1", err_count); end
    n_cmp++; if (state !== 2'b10)    begin n_fail++; $display("FAIL skip_state: got %0d expected 2", state); end
    step(4'd8, 1'b0, 1'b0);
    n_cmp++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL skip_resume_pulse: got %0b expected 0", err_pulse); end
    n_cmp++; if (state !== 2'b10)    begin n_fail++; $display("FAIL skip_resume_state: got %0d expected 2", state); end
    step(4'd9, 1'b0, 1'b1);
    n_cmp++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL skip_clear_count: got %0d expected 0", err_count); end
    n_cmp++; if (state !== 2'b10)    begin n_fail++; $display("FAIL skip_clear_state: got %0d expected 2", state); end
  endtask

  task automatic test_freeze_fault;
    logic [1:0] exp_s;
    for (int k = 0; k < 3; k++) begin
      step(4'd9, 1'b0, 1'b0);
      exp_s = (k < 2) ? 2'b10 : 2'b11;
      n_cmp++; if (err_pulse !== 1'b1)      begin n_fail++; $display("FAIL freeze_pulse %0d: got %0b expected 1", k, err_pulse); end
      n_cmp++; if (err_count !== 8'(k + 1)) begin n_fail++; $display("FAIL freeze_count %0d: got %0d expected %0d", k, err_count, k + 1); end
      n_cmp++; if (state !== exp_s)         begin n_fail++; $display("FAIL freeze_state %0d: got %0d expected %0d", k, state, exp_s); end
    end
    n_cmp++; if (fault !== 1'b1)  begin n_fail++; $display("FAIL fault_flag: got %0b expected 1", fault); end
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL fault_locked: got %0b expected 0", locked); end
    step(4'd9, 1'b0, 1'b0);
    n_cmp++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL fault_quiet_pulse: got %0b expected 0", err_pulse); end
    n_cmp++; if (err_count !== 8'd3) begin n_fail++; $display("FAIL fault_quiet_count: got %0d expected 3", err_count); end
    step(4'd9, 1'b0, 1'b1);
    n_cmp++; if (state !== 2'b01)    begin n_fail++; $display("FAIL unfault_state: got %0d expected 1", state); end
    n_cmp++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL unfault_count: got %0d expected 0", err_count); end
    n_cmp++; if (fault !== 1'b0)     begin n_fail++; $display("FAIL unfault_flag: got %0b expected 0", fault); end
    step(4'd10, 1'b0, 1'b0);
    n_cmp++; if (state !== 2'b10) begin n_fail++; $display("FAIL relock_state: got %0d expected 2", state); end
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL relock_locked: got %0b expected 1", locked); end
  endtask

  task automatic test_clear_priority;
    step(4'd12, 1'b0, 1'b0);
    n_cmp++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL prio_first: got %0d expected 1", err_count); end
    step(4'd14, 1'b0, 1'b1);
    n_cmp++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL prio_count: got %0d expected 1", err_count); end
    n_cmp++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL prio_pulse: got %0b expected 1", err_pulse); end
    n_cmp++; if (state !== 2'b10)    begin n_fail++; $display("FAIL prio_state: got %0d expected 2", state); end
    step(4'd15, 1'b0, 1'b0);
    n_cmp++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL prio_resume: got %0b expected 0", err_pulse); end
    n_cmp++; if (state !== 2'b10)    begin n_fail++; $display("FAIL prio_resume_state: got %0d expected 2", state); end
  endtask

  task automatic test_counter_clear;
    step(4'd0, 1'b0, 1'b0);
    n_cmp++; if (wrap_pulse !== 1'b1) begin n_fail++; $display("FAIL cc_wrap3_pulse: got %0b expected 1", wrap_pulse); end
    n_cmp++; if (wrap_count !== 8'd3) begin n_fail++; $display("FAIL cc_wrap3_count: got %0d expected 3", wrap_count); end
    for (int v = 1; v <= 11; v++) step(4'(v), 1'b0, 1'b0);
    step(4'd12, 1'b1, 1'b0);
    step(4'd0, 1'b0, 1'b0);
    n_cmp++; if (err_pulse !== 1'b0)  begin n_fail++; $display("FAIL cc_err_pulse: got %0b expected 0", err_pulse); end
    n_cmp++; if (wrap_pulse !== 1'b0) begin n_fail++; $display("FAIL cc_wrap_pulse: got %0b expected 0", wrap_pulse); end
    n_cmp++; if (wrap_count !== 8'd3) begin n_fail++; $display("FAIL cc_wrap_count: got %0d expected 3", wrap_count); end
    n_cmp++; if (state !== 2'b10)     begin n_fail++; $display("FAIL cc_state: got %0d expected 2", state); end
    for (int v = 1; v <= 15; v++) step(4'(v), 1'b0, 1'b0);
    step(4'd0, 1'b1, 1'b0);
    n_cmp++; if (wrap_pulse !== 1'b1) begin n_fail++; $display("FAIL ccw_wrap_pulse: got %0b expected 1", wrap_pulse); end
    n_cmp++; if (wrap_count !== 8'd4) begin n_fail++; $display("FAIL ccw_wrap_count: got %0d expected 4", wrap_count); end
    step(4'd0, 1'b1, 1'b0);
    n_cmp++; if (wrap_pulse !== 1'b0) begin n_fail++; $display("FAIL ccw_hold_wrap: got %0b expected 0", wrap_pulse); end
    n_cmp++; if (err_pulse !== 1'b0)  begin n_fail++; $display("FAIL ccw_hold_err: got %0b expected 0", err_pulse); end
    step(4'd0, 1'b0, 1'b0);
    n_cmp++; if (err_pulse !== 1'b0)  begin n_fail++; $display("FAIL ccw_hold2_err: got %0b expected 0", err_pulse); end
    step(4'd1, 1'b0, 1'b0);
    n_cmp++; if (err_count !== 8'd1)  begin n_fail++; $display("FAIL ccw_err_count: got %0d expected 1", err_count); end
    n_cmp++; if (wrap_count !== 8'd4) begin n_fail++; $display("FAIL ccw_wrap_final: got %0d expected 4", wrap_count); end
  endtask

  task automatic test_reset_mid;
    step(4'd3, 1'b0, 1'b0);
    step(4'd4, 1'b0, 1'b0);
    n_cmp++; if (err_count !== 8'd2)  begin n_fail++; $display("FAIL mid_pre_err: got %0d expected 2", err_count); end
    n_cmp++; if (wrap_count !== 8'd4) begin n_fail++; $display("FAIL mid_pre_wrap: got %0d expected 4", wrap_count); end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (state !== 2'b00)     begin n_fail++; $display("FAIL mid_state: got %0d expected 0", state); end
    n_cmp++; if (locked !== 1'b0)     begin n_fail++; $display("FAIL mid_locked: got %0b expected 0", locked); end
    n_cmp++; if (err_count !== 8'd0)  begin n_fail++; $display("FAIL mid_err_count: got %0d expected 0", err_count); end
    n_cmp++; if (wrap_count !== 8'd0) begin n_fail++; $display("FAIL mid_wrap_count: got %0d expected 0", wrap_count); end
    n_cmp++; if (fault !== 1'b0)      begin n_fail++; $display("FAIL mid_fault: got %0b expected 0", fault); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset = 1'b0;
    cnt_in = 4'd0;
    cnt_clr = 1'b0;
    clear_fault = 1'b0;
    test_reset;
    test_lock;
    test_wrap;
    test_skip;
    test_freeze_fault;
    test_clear_priority;
    test_counter_clear;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
